magia_stdio_tx: RTL and testbench

Tile-side initiator for the simulation stdio/EOC protocol. It accepts characters, an error count and a 16-bit exit code from the core-side MMIO path, and issues single-beat AXI4 writes:
- characters to the hart's stdout address;
- the error count to the stderr address;
- the exit code to the EOC mailbox in L2.

It sits between the tile's MMIO decode and the tile AXI crossbar master port that leads to L2.

---
 rtl/magia_stdio_tx.sv | 201 ++++++++++++++++++++
 tb/tb_magia_stdio_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/magia_stdio_tx.sv
// Tile-side stdio/EOC initiator: turns MMIO characters, error counts and the exit code into
// single-beat AXI4 writes, one transaction outstanding at a time.
module magia_stdio_tx #(
  parameter int unsigned HART_ID     = 0,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ID_W        = 2,
  parameter logic [31:0] STDOUT_BASE = 32'hFFFF0004,
  parameter logic [31:0] STDERR_ADDR = 32'hFFFF0000,
  parameter logic [31:0] EOC_BASE    = 32'hCC030000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            char_valid_i,
  input  logic [7:0]      char_data_i,
  output logic            char_ready_o,
  input  logic            err_valid_i,
  input  logic [7:0]      err_count_i,
  output logic            err_ready_o,
  input  logic            exit_valid_i,
  input  logic [15:0]     exit_code_i,
  output logic            exit_ready_o,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  output logic [31:0]     aw_addr_o,
  output logic [ID_W-1:0] aw_id_o,
  output logic [7:0]      aw_len_o,
  output logic [2:0]      aw_size_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic [31:0]     w_data_o,
  output logic [3:0]      w_strb_o,
  output logic            w_last_o,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  input  logic [1:0]      b_resp_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            resp_err_o,
  output logic [15:0]     chars_sent_o
);

  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] StdoutAddr = STDOUT_BASE + 32'(4 * HART_ID);
  localparam logic [31:0] EocAddr    = EOC_BASE + 32'(2 * HART_ID);
  localparam logic [31:0] HartIdVec  = 32'(HART_ID);
  localparam logic        ExitLane   = EocAddr[1];

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_empty, fifo_full, push, pop;

  logic        err_pending_q, err_take;
  logic [7:0]  err_data_q;

  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  size_q, size_d;
  logic        is_char_q, is_char_d, is_exit_q, is_exit_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] chars_sent_q, chars_sent_d;

  // Extra MSB on each pointer tells a full FIFO from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign done_o       = (state_q == StDone);
  assign char_ready_o = !fifo_full && !done_o;
  assign err_ready_o  = !err_pending_q && !done_o;
  assign exit_ready_o = (state_q == StIdle) && fifo_empty && !err_pending_q && !done_o &&
                        !char_valid_i;
  assign push         = char_valid_i && char_ready_o;

  assign aw_valid_o   = (state_q == StAddr) && !aw_done_q;
  assign w_valid_o    = (state_q == StAddr) && !w_done_q;
  assign b_ready_o    = (state_q == StResp);
  assign aw_addr_o    = addr_q;
  assign aw_id_o      = HartIdVec[ID_W-1:0];
  assign aw_len_o     = 8'd0;
  assign aw_size_o    = size_q;
  assign w_data_o     = data_q;
  assign w_strb_o     = strb_q;
  assign w_last_o     = 1'b1;
  assign busy_o       = !fifo_empty || (state_q == StAddr) || (state_q == StResp);
  assign resp_err_o   = resp_err_q;
  assign chars_sent_o = chars_sent_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= char_data_i;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    strb_d       = strb_q;
    size_d       = size_q;
    is_char_d    = is_char_q;
    is_exit_d    = is_exit_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_err_d   = resp_err_q;
    chars_sent_d = chars_sent_q;
    pop          = 1'b0;
    err_take     = 1'b0;
    unique case (state_q)
      StIdle: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (err_pending_q) begin
          addr_d    = STDERR_ADDR;
          data_d    = {24'b0, err_data_q};
          strb_d    = 4'b0001;
          size_d    = 3'd0;
          is_char_d = 1'b0;
          is_exit_d = 1'b0;
          err_take  = 1'b1;
          state_d   = StAddr;
        end else if (!fifo_empty) begin
          addr_d    = StdoutAddr;
          data_d    = {24'b0, fifo_mem[rd_ptr_q[PtrW-1:0]]};
          strb_d    = 4'b0001;
          size_d    = 3'd0;
          is_char_d = 1'b1;
          is_exit_d = 1'b0;
          pop       = 1'b1;
          state_d   = StAddr;
        end else if (exit_valid_i && exit_ready_o) begin
          addr_d    = EocAddr;
          data_d    = ExitLane ? {exit_code_i, 16'h0000} : {16'h0000, exit_code_i};
          strb_d    = ExitLane ? 4'b1100 : 4'b0011;
          size_d    = 3'd1;
          is_char_d = 1'b0;
          is_exit_d = 1'b1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (aw_valid_o && aw_ready_i) aw_done_d = 1'b1;
        if (w_valid_o && w_ready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)    state_d   = StResp;
      end
      StResp: begin
        if (b_valid_i) begin
          if (b_resp_i != 2'b00) resp_err_d = 1'b1;
          if (is_char_q && (chars_sent_q != 16'hFFFF)) chars_sent_d = chars_sent_q + 16'd1;
          state_d = is_exit_q ? StDone : StIdle;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  // Reset input is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_pending_q <= 1'b0;
      err_data_q    <= 8'd0;
      addr_q        <= 32'd0;
      data_q        <= 32'd0;
      strb_q        <= 4'd0;
      size_q        <= 3'd0;
      is_char_q     <= 1'b0;
      is_exit_q     <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      resp_err_q    <= 1'b0;
      chars_sent_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
      size_q       <= size_d;
      is_char_q    <= is_char_d;
      is_exit_q    <= is_exit_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_err_q   <= resp_err_d;
      chars_sent_q <= chars_sent_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (err_take) begin
        err_pending_q <= 1'b0;
      end else if (err_valid_i && err_ready_o) begin
        err_pending_q <= 1'b1;
        err_data_q    <= err_count_i;
      end
    end
  end

endmodule

// File: tb/tb_magia_stdio_tx.sv
// Bench for magia_stdio_tx: directed steps with random payloads and handshake timing, checked
// against an ordered list of expected AXI writes.
module tb_magia_stdio_tx;

  localparam int unsigned Hart    = 3;
  localparam int unsigned Depth   = 8;
  localparam logic [31:0] StdoutA = 32'hFFFF0004 + 32'(4 * Hart);
  localparam logic [31:0] StderrA = 32'hFFFF0000;
  localparam logic [31:0] EocA    = 32'hCC030000 + 32'(2 * Hart);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        char_valid = 1'b0, err_valid = 1'b0, exit_valid = 1'b0;
  logic [7:0]  char_data = 8'd0, err_count = 8'd0;
  logic [15:0] exit_code = 16'd0;
  logic        char_ready, err_ready, exit_ready;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [1:0]  aw_id, b_resp;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [3:0]  w_strb;
  logic        busy, done, resp_err;
  logic [15:0] chars_sent;

  always #5 clk = ~clk;

  magia_stdio_tx #(.HART_ID(Hart), .FIFO_DEPTH(Depth), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_valid_i(char_valid), .char_data_i(char_data), .char_ready_o(char_ready),
    .err_valid_i(err_valid), .err_count_i(err_count), .err_ready_o(err_ready),
    .exit_valid_i(exit_valid), .exit_code_i(exit_code), .exit_ready_o(exit_ready),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
    .aw_len_o(aw_len), .aw_size_o(aw_size),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .w_last_o(w_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .busy_o(busy), .done_o(done), .resp_err_o(resp_err), .chars_sent_o(chars_sent)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
    bit          is_char;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0, failures = 0;
  int          idx = 0, cyc = 0, b_cnt = 0, chars_exp = 0, aw_hold_until = 0;
  bit          rnd_mode = 0, b_hold = 0, aw_seen = 0, w_seen = 0, b_hs_prev = 0;
  logic [1:0]  resp_next = 2'b00;
  logic        resp_err_exp = 1'b0;
  logic [1:0]  hid = 2'(Hart);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic add_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] sz, input bit ch);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s; e.size = sz; e.is_char = ch;
    exp_q.push_back(e);
  endtask

  // AXI slave and write checker; inputs for the coming edge are set on the falling edge,
  // then the handshakes that edge will complete are checked against the expected list.
  initial begin : axi_side
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        idx = exp_q.size(); aw_seen = 0; w_seen = 0; b_hs_prev = 0;
        chars_exp = 0; resp_err_exp = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
      end else begin
        aw_ready = (cyc >= aw_hold_until) && (!rnd_mode || $urandom_range(0, 1) == 1);
        w_ready  = !rnd_mode || $urandom_range(0, 1) == 1;
        if (b_hs_prev) b_valid = 1'b0;
        else if (!b_valid && aw_seen && w_seen && !b_hold &&
                 (!rnd_mode || $urandom_range(0, 2) != 0)) begin
          b_valid = 1'b1;
          b_resp  = resp_next;
        end
        b_hs_prev = 0;
        #1;
        chk("aw_extra", 32'(aw_valid && (aw_seen || idx >= exp_q.size())), 0);
        chk("w_extra", 32'(w_valid && (w_seen || idx >= exp_q.size())), 0);
        chk("b_ready_early", 32'(b_ready && !(aw_seen && w_seen)), 0);
        if (aw_valid && !aw_seen && idx < exp_q.size()) begin
          chk("aw_addr", aw_addr, exp_q[idx].addr);
          chk("aw_len_size_id", 32'({aw_len, aw_size, aw_id}), 32'({8'd0, exp_q[idx].size, hid}));
        end
        if (w_valid && !w_seen && idx < exp_q.size()) begin
          chk("w_data", w_data, exp_q[idx].data);
          chk("w_strb_last", 32'({w_strb, w_last}), 32'({exp_q[idx].strb, 1'b1}));
        end
        if (aw_valid && aw_ready) aw_seen = 1;
        if (w_valid && w_ready) w_seen = 1;
        if (b_valid && b_ready) begin
          if (idx < exp_q.size() && exp_q[idx].is_char && chars_exp < 65535) chars_exp++;
          if (b_resp != 2'b00) resp_err_exp = 1'b1;
          idx++; b_cnt++;
          aw_seen = 0; w_seen = 0; b_hs_prev = 1;
        end
      end
    end
  end

  task automatic push_char(input logic [7:0] c, output bit stalled);
    int n = 0;
    char_valid = 1'b1; char_data = c; stalled = 0;
    while (!char_ready && n < 300) begin
      stalled = 1;
      @(negedge clk);
      n++;
    end
    chk("char_accept", 32'(char_ready), 1);
    add_exp(StdoutA, {24'b0, c}, 4'b0001, 3'd0, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || idx != exp_q.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_writes_done"}, 32'(idx), 32'(exp_q.size()));
    chk({tag, "_chars_sent"}, 32'(chars_sent), 32'(chars_exp));
    chk({tag, "_resp_err"}, 32'(resp_err), 32'(resp_err_exp));
  endtask

  initial begin : main
    bit st;
    int first_stall, n, b0;
    logic [31:0] ea;
    logic [15:0] code;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({aw_valid, w_valid, b_ready, busy, done, resp_err}), 0);
    chk("reset_chars", 32'(chars_sent), 0);
    #2 rst_n = 1'b0;
    @(negedge clk);

    // Two characters, slave always ready.
    push_char(8'h48, st);
    push_char(8'h0A, st);
    char_valid = 1'b0;
    wait_idle("t1");
    chk("t1_chars_two", 32'(chars_sent), 2);

    // Twelve back-to-back characters against a stalled AW channel.
    aw_hold_until = cyc + 20;
    first_stall = -1;
    for (int i = 0; i < 12; i++) begin
      push_char(8'($urandom), st);
      if (st && first_stall < 0) first_stall = i;
    end
    char_valid = 1'b0;
    chk("t2_accepted_before_full", 32'(first_stall), 9);
    wait_idle("t2");

    // Character and error count offered together: error goes first.
    char_valid = 1'b1; char_data = 8'h41; err_valid = 1'b1; err_count = 8'h05;
    chk("t3_ready", 32'({char_ready, err_ready}), 32'b11);
    add_exp(StderrA, 32'h5, 4'b0001, 3'd0, 1'b0);
    add_exp(StdoutA, 32'h41, 4'b0001, 3'd0, 1'b1);
    @(negedge clk);
    char_valid = 1'b0; err_valid = 1'b0;
    wait_idle("t3");

    // Random characters, gaps and handshake timing.
    rnd_mode = 1;
    for (int i = 0; i < 20; i++) begin
      push_char(8'($urandom), st);
      if ($urandom_range(0, 3) == 0) begin
        char_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    char_valid = 1'b0;
    wait_idle("rnd");

    // W completes well before AW, then a SLVERR response; the error flag is sticky.
    rnd_mode = 0;
    b0 = b_cnt;
    aw_hold_until = cyc + 6;
    resp_next = 2'b10;
    push_char(8'h5A, st);
    char_valid = 1'b0;
    wait_idle("t5a");
    chk("t5_one_b", 32'(b_cnt - b0), 1);
    chk("t5_err_set", 32'(resp_err), 1);
    resp_next = 2'b00;
    push_char(8'($urandom), st);
    push_char(8'($urandom), st);
    char_valid = 1'b0;
    wait_idle("t5b");
    chk("t5_err_sticky", 32'(resp_err), 1);

    // Reset while waiting for B with four characters still queued.
    b_hold = 1;
    for (int i = 0; i < 5; i++) push_char(8'($urandom), st);
    char_valid = 1'b0;
    n = 0;
    while (!b_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_resp", 32'(b_ready), 1);
    #2 rst_n = 1'b1;
    #1 chk("t6_reset_async", 32'({aw_valid, w_valid, b_ready, busy, done, resp_err}), 0);
    repeat (2) @(negedge clk);
    b_hold = 0;
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_busy_after", 32'(busy), 0);
    chk("t6_chars_after", 32'(chars_sent), 0);
    chk("t6_no_replay", 32'(idx), 32'(exp_q.size()));

    // Exit code after three characters; everything closes afterwards.
    rnd_mode = 1;
    for (int i = 0; i < 3; i++) push_char(8'($urandom), st);
    char_valid = 1'b0;
    code = 16'h0001;
    exit_valid = 1'b1; exit_code = code;
    n = 0;
    while (!exit_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_exit_ready", 32'(exit_ready), 1);
    chk("t4_chars_before_exit", 32'(chars_sent), 3);
    ea = EocA;
    add_exp(ea, ea[1] ? {code, 16'h0} : {16'h0, code}, ea[1] ? 4'b1100 : 4'b0011, 3'd1, 1'b0);
    @(negedge clk);
    exit_valid = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_done", 32'(done), 1);
    chk("t4_writes_done", 32'(idx), 32'(exp_q.size()));
    char_valid = 1'b1; err_valid = 1'b1; exit_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_closed", 32'({char_ready, err_ready, exit_ready, busy}), 0);
    end
    char_valid = 1'b0; err_valid = 1'b0; exit_valid = 1'b0;
    chk("t4_chars_final", 32'(chars_sent), 32'(chars_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
